// File: rtl/vga_frame_fetch_pkg.sv
// Shared widths, pixel struct and colour helpers for the frame fetch block.
package vga_frame_fetch_pkg;
  localparam int X_W = 10;
  localparam int Y_W = 9;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  function automatic rgb_t gray_to_rgb(input logic [7:0] v);
    rgb_t c;
    c.r = v;
    c.g = v;
    c.b = v;
    return c;
  endfunction
endpackage

// File: rtl/vga_frame_fetch_if.sv
// Image load handshake plus video-driver coordinate/pixel bus.
interface vga_frame_fetch_if #(
  parameter int IMG_W    = 28,
  parameter int IMG_H    = 28,
  parameter int CHANNELS = 1
) ();
  import vga_frame_fetch_pkg::*;

  localparam int IMG_BITS = IMG_W * IMG_H * CHANNELS * 8;

  logic [IMG_BITS-1:0] img_in;
  logic                img_valid;
  logic                img_ready;
  logic [X_W-1:0]      x;
  logic [Y_W-1:0]      y;
  logic [7:0]          pix_r;
  logic [7:0]          pix_g;
  logic [7:0]          pix_b;
  logic                in_image;
  logic                frame_swap;

  modport master (
    output img_in, img_valid, x, y,
    input  img_ready, pix_r, pix_g, pix_b, in_image, frame_swap
  );

  modport slave (
    input  img_in, img_valid, x, y,
    output img_ready, pix_r, pix_g, pix_b, in_image, frame_swap
  );
endinterface

// File: rtl/vga_frame_fetch_image_bank.sv
// Shadow/active image banks: loads into shadow, promotes to active on frame start.
module vga_frame_fetch_image_bank
  import vga_frame_fetch_pkg::*;
#(
  parameter int IMG_W    = 28,
  parameter int IMG_H    = 28,
  parameter int CHANNELS = 1,
  localparam int NPIX    = IMG_W * IMG_H,
  localparam int PW      = CHANNELS * 8,
  localparam int AW      = $clog2(NPIX)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NPIX*PW-1:0] img_in,
  input  logic               img_valid,
  output logic               img_ready,
  input  logic               fs,
  output logic               frame_swap,
  input  logic [AW-1:0]      rd_addr,
  output logic [PW-1:0]      rd_data
);
  logic [PW-1:0] shadow_q [NPIX];
  logic [PW-1:0] active_q [NPIX];
  logic          pending_q;
  logic          swap_q;
  logic          load_en;
  logic          swap_en;

  // Load and swap are mutually exclusive: loads only happen while nothing is pending.
  assign load_en = img_valid && !pending_q;
  assign swap_en = fs && pending_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < NPIX; p++) begin
        shadow_q[p] <= '0;
        active_q[p] <= '0;
      end
      pending_q <= 1'b0;
      swap_q    <= 1'b0;
    end else begin
      swap_q <= 1'b0;
      if (load_en) begin
        for (int p = 0; p < NPIX; p++) shadow_q[p] <= img_in[p*PW +: PW];
        pending_q <= 1'b1;
      end else if (swap_en) begin
        for (int p = 0; p < NPIX; p++) active_q[p] <= shadow_q[p];
        pending_q <= 1'b0;
        swap_q    <= 1'b1;
      end
    end
  end

  assign img_ready  = !pending_q;
  assign frame_swap = swap_q;
  assign rd_data    = active_q[rd_addr];
endmodule

// File: rtl/vga_frame_fetch.sv
// Double-buffered upscaling image source: two-stage (map, fetch) pixel pipeline.
module vga_frame_fetch
  import vga_frame_fetch_pkg::*;
#(
  parameter int         IMG_W      = 28,
  parameter int         IMG_H      = 28,
  parameter int         CHANNELS   = 1,
  parameter int         SCALE_LOG2 = 2,
  parameter int         X0         = 0,
  parameter int         Y0         = 0,
  parameter logic [7:0] BG_VALUE   = 8'h00
) (
  input logic              clk,
  input logic              reset,
  vga_frame_fetch_if.slave bus
);
  localparam int NPIX = IMG_W * IMG_H;
  localparam int PW   = CHANNELS * 8;
  localparam int AW   = $clog2(NPIX);
  localparam logic signed [X_W:0] X0_S    = (X_W+1)'(X0);
  localparam logic signed [Y_W:0] Y0_S    = (Y_W+1)'(Y0);
  localparam logic signed [X_W:0] X_LIM_S = (X_W+1)'(IMG_W << SCALE_LOG2);
  localparam logic signed [Y_W:0] Y_LIM_S = (Y_W+1)'(IMG_H << SCALE_LOG2);

  logic [X_W-1:0]      prev_x_q;
  logic [Y_W-1:0]      prev_y_q;
  logic                fs;
  logic signed [X_W:0] dx;
  logic signed [Y_W:0] dy;
  logic                inside_d, inside_q;
  logic [AW-1:0]       addr_d, addr_q;
  logic [PW-1:0]       rd_data;
  rgb_t                src_rgb;
  rgb_t                bg_rgb;
  rgb_t                pix_d, pix_q;
  logic                in_image_q;

  // prev_xy resets to all-ones so the first (0,0) after reset is a frame start.
  assign fs = (bus.x == '0) && (bus.y == '0) && !((prev_x_q == '0) && (prev_y_q == '0));

  assign dx = $signed({1'b0, bus.x}) - X0_S;
  assign dy = $signed({1'b0, bus.y}) - Y0_S;

  always_comb begin
    inside_d = !dx[X_W] && !dy[Y_W] && (dx < X_LIM_S) && (dy < Y_LIM_S);
    addr_d   = AW'(32'(dy[Y_W-1:0] >> SCALE_LOG2) * IMG_W + 32'(dx[X_W-1:0] >> SCALE_LOG2));
  end

  vga_frame_fetch_image_bank #(
    .IMG_W    (IMG_W),
    .IMG_H    (IMG_H),
    .CHANNELS (CHANNELS)
  ) u_bank (
    .clk        (clk),
    .reset      (reset),
    .img_in     (bus.img_in),
    .img_valid  (bus.img_valid),
    .img_ready  (bus.img_ready),
    .fs         (fs),
    .frame_swap (bus.frame_swap),
    .rd_addr    (addr_q),
    .rd_data    (rd_data)
  );

  generate
    if (CHANNELS == 3) begin : g_rgb
      assign src_rgb = rgb_t'(rd_data[23:0]);
    end else begin : g_gray
      assign src_rgb = gray_to_rgb(rd_data[7:0]);
    end
  endgenerate

  assign bg_rgb = gray_to_rgb(BG_VALUE);
  assign pix_d  = inside_q ? src_rgb : bg_rgb;

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_x_q   <= '1;
      prev_y_q   <= '1;
      inside_q   <= 1'b0;
      addr_q     <= '0;
      pix_q      <= '0;
      in_image_q <= 1'b0;
    end else begin
      prev_x_q   <= bus.x;
      prev_y_q   <= bus.y;
      inside_q   <= inside_d;
      addr_q     <= addr_d;
      pix_q      <= pix_d;
      in_image_q <= inside_q;
    end
  end

  assign bus.pix_r    = pix_q.r;
  assign bus.pix_g    = pix_q.g;
  assign bus.pix_b    = pix_q.b;
  assign bus.in_image = in_image_q;
endmodule

// File: tb/tb_vga_frame_fetch.sv
// Directed bench: default, offset/background and RGB instances share clk/reset.
module tb_vga_frame_fetch;
  import vga_frame_fetch_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  vga_frame_fetch_if #(.IMG_W(28), .IMG_H(28), .CHANNELS(1)) bus0 ();
  vga_frame_fetch_if #(.IMG_W(28), .IMG_H(28), .CHANNELS(1)) bus1 ();
  vga_frame_fetch_if #(.IMG_W(4),  .IMG_H(4),  .CHANNELS(3)) bus2 ();

  vga_frame_fetch #(
    .IMG_W(28), .IMG_H(28), .CHANNELS(1), .SCALE_LOG2(2),
    .X0(0), .Y0(0), .BG_VALUE(8'h00)
  ) dut0 (.clk(clk), .reset(reset), .bus(bus0));

  vga_frame_fetch #(
    .IMG_W(28), .IMG_H(28), .CHANNELS(1), .SCALE_LOG2(2),
    .X0(100), .Y0(50), .BG_VALUE(8'h20)
  ) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  vga_frame_fetch #(
    .IMG_W(4), .IMG_H(4), .CHANNELS(3), .SCALE_LOG2(2),
    .X0(0), .Y0(0), .BG_VALUE(8'h00)
  ) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  logic [28*28*8-1:0] ramp_img, a_img, b_img, c_img;
  logic [4*4*24-1:0]  rgb_img;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_xy(input int xv, input int yv);
    bus0.x = 10'(xv); bus0.y = 9'(yv);
    bus1.x = 10'(xv); bus1.y = 9'(yv);
    bus2.x = 10'(xv); bus2.y = 9'(yv);
  endtask

  task automatic chk0(input string tag, input logic [7:0] v, input logic inimg);
    check({tag, ".r0"}, 32'(bus0.pix_r), 32'(v));
    check({tag, ".g0"}, 32'(bus0.pix_g), 32'(v));
    check({tag, ".b0"}, 32'(bus0.pix_b), 32'(v));
    check({tag, ".in0"}, 32'(bus0.in_image), 32'(inimg));
  endtask

  task automatic chk1(input string tag, input logic [7:0] v, input logic inimg);
    check({tag, ".r1"}, 32'(bus1.pix_r), 32'(v));
    check({tag, ".b1"}, 32'(bus1.pix_b), 32'(v));
    check({tag, ".in1"}, 32'(bus1.in_image), 32'(inimg));
  endtask

  task automatic chk2(input string tag, input logic [23:0] v, input logic inimg);
    check({tag, ".r2"}, 32'(bus2.pix_r), 32'(v[23:16]));
    check({tag, ".g2"}, 32'(bus2.pix_g), 32'(v[15:8]));
    check({tag, ".b2"}, 32'(bus2.pix_b), 32'(v[7:0]));
    check({tag, ".in2"}, 32'(bus2.in_image), 32'(inimg));
  endtask

  task automatic point(input int xv, input int yv);
    set_xy(xv, yv);
    tick();
    tick();
  endtask

  initial begin
    for (int p = 0; p < 784; p++) begin
      ramp_img[p*8 +: 8] = 8'(p % 256);
      a_img[p*8 +: 8]    = 8'hA5;
      b_img[p*8 +: 8]    = 8'h5B;
      c_img[p*8 +: 8]    = 8'h77;
    end
    for (int p = 0; p < 16; p++)
      rgb_img[p*24 +: 24] = (p == 0) ? 24'hFF8010 : {8'(p), 8'(p + 1), 8'(p + 2)};

    reset = 1'b1;
    bus0.img_in = '0; bus0.img_valid = 1'b0;
    bus1.img_in = '0; bus1.img_valid = 1'b0;
    bus2.img_in = '0; bus2.img_valid = 1'b0;
    set_xy(0, 0);
    repeat (3) tick();

    $display("step: reset state");
    check("rst.ready0", 32'(bus0.img_ready), 32'd1);
    check("rst.swap0", 32'(bus0.frame_swap), 32'd0);
    chk0("rst", 8'h00, 1'b0);
    chk1("rst", 8'h00, 1'b0);
    reset = 1'b0;

    $display("step: sweep with no load");
    for (int yy = 0; yy < 480; yy += 31) begin
      for (int xx = 0; xx < 640; xx += 37) begin
        set_xy(xx, yy);
        tick();
        check("sweep.swap_a", 32'(bus0.frame_swap), 32'd0);
        tick();
        check("sweep.swap_b", 32'(bus0.frame_swap), 32'd0);
        check("sweep.pix", 32'(bus0.pix_r), 32'd0);
        check("sweep.in", 32'(bus0.in_image), 32'((xx < 112) && (yy < 112)));
      end
    end
    check("sweep.ready0", 32'(bus0.img_ready), 32'd1);

    $display("step: load ramp/rgb, frame start swap");
    set_xy(5, 5);
    bus0.img_in = ramp_img; bus0.img_valid = 1'b1;
    bus1.img_in = ramp_img; bus1.img_valid = 1'b1;
    bus2.img_in = rgb_img;  bus2.img_valid = 1'b1;
    tick();
    bus0.img_valid = 1'b0; bus1.img_valid = 1'b0; bus2.img_valid = 1'b0;
    check("load.ready0", 32'(bus0.img_ready), 32'd0);
    check("load.ready2", 32'(bus2.img_ready), 32'd0);
    tick();
    set_xy(0, 0);
    tick();
    check("fs.swap0", 32'(bus0.frame_swap), 32'd1);
    check("fs.swap1", 32'(bus1.frame_swap), 32'd1);
    check("fs.swap2", 32'(bus2.frame_swap), 32'd1);
    tick();
    check("fs.swap0_end", 32'(bus0.frame_swap), 32'd0);
    check("fs.ready0", 32'(bus0.img_ready), 32'd1);
    chk0("fs00", 8'h00, 1'b1);
    chk1("fs00", 8'h20, 1'b0);
    chk2("fs00", 24'hFF8010, 1'b1);
    point(7, 5);
    chk0("p7_5", 8'h1D, 1'b1);
    chk1("p7_5", 8'h20, 1'b0);
    chk2("p7_5", 24'h050607, 1'b1);

    $display("step: load A, B held while pending");
    bus0.img_in = a_img; bus0.img_valid = 1'b1;
    tick();
    check("ab.ready_a", 32'(bus0.img_ready), 32'd0);
    bus0.img_in = b_img;
    tick();
    tick();
    check("ab.ready_b", 32'(bus0.img_ready), 32'd0);
    bus0.img_valid = 1'b0;
    chk0("ab.old", 8'h1D, 1'b1);
    set_xy(0, 0);
    tick();
    check("ab.swap", 32'(bus0.frame_swap), 32'd1);
    tick();
    chk0("ab.fs00", 8'hA5, 1'b1);
    check("ab.ready_end", 32'(bus0.img_ready), 32'd1);
    point(50, 60);
    chk0("ab.p50_60", 8'hA5, 1'b1);

    $display("step: offset boundaries");
    point(99, 50);
    chk1("b99_50", 8'h20, 1'b0);
    point(212, 50);
    chk1("b212_50", 8'h20, 1'b0);
    point(100, 50);
    chk1("b100_50", 8'h00, 1'b1);
    point(211, 161);
    chk1("b211_161", 8'h0F, 1'b1);
    chk0("nowrap211_161", 8'h00, 1'b0);
    point(100, 162);
    chk1("b100_162", 8'h20, 1'b0);

    $display("step: rgb boundaries");
    point(16, 0);
    chk2("rgb16_0", 24'h000000, 1'b0);
    point(15, 15);
    chk2("rgb15_15", 24'h0F1011, 1'b1);

    $display("step: reset with pending load");
    set_xy(9, 9);
    bus0.img_in = c_img; bus0.img_valid = 1'b1;
    tick();
    bus0.img_valid = 1'b0;
    check("rp.ready_pend", 32'(bus0.img_ready), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rp.ready", 32'(bus0.img_ready), 32'd1);
    chk0("rp.c1", 8'h00, 1'b0);
    tick();
    chk0("rp.c2", 8'h00, 1'b0);
    tick();
    chk0("rp.c3", 8'h00, 1'b1);
    set_xy(1, 1);
    tick();
    set_xy(0, 0);
    tick();
    check("rp.noswap_a", 32'(bus0.frame_swap), 32'd0);
    tick();
    check("rp.noswap_b", 32'(bus0.frame_swap), 32'd0);
    chk0("rp.fs00", 8'h00, 1'b1);
    check("rp.ready_end", 32'(bus0.img_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
